// File: rtl/demux_rr_nx1.sv
// demux_rr_nx1: registered 1-to-NUM_CH demultiplexer with two routing modes.
//   mode 0 routes to 'select'. mode 1 routes round-robin from rr_ptr and
//   skips channels whose downstream FIFO asserts pause.
// Ports:
//   clk, reset      clock; asynchronous active-low reset
//   data_in         input word
//   valid_in        data_in carries a word this cycle
//   mode            0 = explicit select, 1 = round-robin
//   select          target channel in mode 0
//   pause           per-channel downstream backpressure (1 = do not write)
//   ready_out       combinational: a word presented now would be accepted
//   data_out        flattened channel words; channel i at [i*DATA_WIDTH +: DATA_WIDTH]
//   valid_out       registered one-cycle write strobe per channel
//   rr_ptr          registered round-robin start pointer
//   err_drop        registered one-cycle pulse when a presented word is rejected
module demux_rr_nx1 #(
  parameter int unsigned DATA_WIDTH = 10,
  parameter int unsigned NUM_CH     = 4,
  parameter int unsigned SEL_WIDTH  = 2
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic [DATA_WIDTH-1:0]        data_in,
  input  logic                         valid_in,
  input  logic                         mode,
  input  logic [SEL_WIDTH-1:0]         select,
  input  logic [NUM_CH-1:0]            pause,
  output logic                         ready_out,
  output logic [NUM_CH*DATA_WIDTH-1:0] data_out,
  output logic [NUM_CH-1:0]            valid_out,
  output logic [SEL_WIDTH-1:0]         rr_ptr,
  output logic                         err_drop
);

  localparam int unsigned DOUT_W = NUM_CH * DATA_WIDTH;

  logic [DOUT_W-1:0]    data_out_q,  data_out_d;
  logic [NUM_CH-1:0]    valid_out_q, valid_out_d;
  logic [SEL_WIDTH-1:0] rr_ptr_q,    rr_ptr_d;
  logic                 err_drop_q,  err_drop_d;

  logic [SEL_WIDTH-1:0] rr_target;
  logic                 rr_found;
  logic [SEL_WIDTH-1:0] target;
  logic                 ready;
  logic                 accept;

  // Round-robin search: first unpaused channel at or after rr_ptr, wrapping.
  always_comb begin
    int unsigned          idx;
    logic [SEL_WIDTH-1:0] idx_s;
    rr_target = rr_ptr_q;
    rr_found  = 1'b0;
    idx       = 0;
    idx_s     = '0;
    for (int unsigned k = 0; k < NUM_CH; k++) begin
      // rr_ptr_q < NUM_CH, so one conditional subtract implements the modulo.
      idx = 32'(rr_ptr_q) + k;
      if (idx >= NUM_CH) idx = idx - NUM_CH;
      idx_s = SEL_WIDTH'(idx);
      if (!rr_found && !pause[idx_s]) begin
        rr_found  = 1'b1;
        rr_target = idx_s;
      end
    end
  end

  // Mode mux for target and readiness; independent of valid_in.
  always_comb begin
    target = select;
    ready  = 1'b0;
    if (mode) begin
      target = rr_target;
      ready  = rr_found;
    end else begin
      // Guard keeps non-power-of-two NUM_CH from indexing past pause.
      ready = (32'(select) < NUM_CH) && !pause[select];
    end
  end

  assign accept    = valid_in && ready;
  assign ready_out = ready;

  // Next-state for strobes, channel words, pointer and drop flag.
  always_comb begin
    valid_out_d = '0;
    data_out_d  = data_out_q;
    rr_ptr_d    = rr_ptr_q;
    err_drop_d  = valid_in && !ready;
    for (int unsigned c = 0; c < NUM_CH; c++) begin
      if (accept && (target == SEL_WIDTH'(c))) begin
        valid_out_d[c]                          = 1'b1;
        data_out_d[c*DATA_WIDTH +: DATA_WIDTH] = data_in;
      end
    end
    if (mode && accept) begin
      if (32'(target) == NUM_CH - 1) rr_ptr_d = '0;
      else                           rr_ptr_d = target + SEL_WIDTH'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      data_out_q  <= '0;
      valid_out_q <= '0;
      rr_ptr_q    <= '0;
      err_drop_q  <= 1'b0;
    end else begin
      data_out_q  <= data_out_d;
      valid_out_q <= valid_out_d;
      rr_ptr_q    <= rr_ptr_d;
      err_drop_q  <= err_drop_d;
    end
  end

  assign data_out  = data_out_q;
  assign valid_out = valid_out_q;
  assign rr_ptr    = rr_ptr_q;
  assign err_drop  = err_drop_q;

endmodule

// File: doc/demux_rr_nx1.md
# demux_rr_nx1

Parametrised registered 1-to-N demultiplexer for the round-robin datapath. It routes one DATA_WIDTH-bit word per cycle from a single input into one of NUM_CH output channels, each feeding a downstream FIFO. It has two routing modes: explicit select, or round-robin that skips channels whose FIFO reports pause. It adds per-channel valid outputs, a ready/backpressure signal toward the source, and a drop flag when a word cannot be delivered.

## Interface
- DATA_WIDTH, 10, width of each data word.
- NUM_CH, 4, number of output channels (2..16).
- SEL_WIDTH, 2, width of select and rr_ptr; must equal clog2(NUM_CH).
- clk  input  1  single clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-low reset (0 = reset asserted).
- data_in  input  DATA_WIDTH  input word.
- valid_in  input  1  data_in carries a word this cycle.
- mode  input  1  0 = explicit select, 1 = round-robin.
- select  input  SEL_WIDTH  target channel in mode 0; ignored in mode 1.
- pause  input  NUM_CH  per-channel backpressure from downstream FIFOs (1 = do not write).
- ready_out  output  1  combinational; a word presented this cycle will be accepted.
- data_out  output  NUM_CH*DATA_WIDTH  flattened; channel i occupies bits [i*DATA_WIDTH +: DATA_WIDTH].
- valid_out  output  NUM_CH  registered one-cycle write strobe per channel.
- rr_ptr  output  SEL_WIDTH  registered round-robin start pointer.
- err_drop  output  1  registered one-cycle pulse; a word was presented but not accepted.

## Operation
- Target selection (combinational):
  - Mode 0: target = select. ready_out = (select < NUM_CH) && !pause[select].
  - Mode 1: target = first channel with pause=0, searching rr_ptr, rr_ptr+1, … modulo NUM_CH. ready_out = |(~pause).
- ready_out depends only on mode, select, pause and rr_ptr, never on valid_in.
- Accept = valid_in && ready_out. On accept, at the next edge:
  - valid_out[target] goes to 1 and all other valid_out bits go to 0.
  - Channel target's slice of data_out loads data_in.
- On a cycle without accept, valid_out goes to all zeros at the next edge.
- Non-target data_out slices always hold their last value.
- rr_ptr:
  - Mode 1 accept: rr_ptr becomes (target+1) mod NUM_CH. Wrap is from NUM_CH-1 to 0.
  - Mode 1 without accept: rr_ptr holds.
  - Mode 0: rr_ptr always holds, so round-robin resumes from the same place when mode returns to 1.
- Drop: valid_in && !ready_out sets err_drop=1 for the next cycle only. The word is discarded and no state changes.
- Mode or select may change every cycle. Each cycle is evaluated independently with the current inputs.
- Reset (reset=0):
  - Outputs clear immediately, independent of clk: valid_out=0, data_out=0, rr_ptr=0, err_drop=0.
  - ready_out reflects the cleared rr_ptr.
  - While reset=0, no word is accepted and valid_in is ignored (no err_drop).
  - Normal operation resumes on the first rising edge after reset returns to 1.

## Timing
- Latency: 1 cycle from accept edge to valid_out/data_out.
- Throughput: one word per cycle, with no bubbles across channel switches.
- The combinational path pause/select/rr_ptr -> ready_out is a priority search of at most NUM_CH stages.
- valid_out is a single-cycle strobe. Back-to-back accepts to the same channel hold that valid_out bit high on consecutive cycles.
- err_drop is asserted in the cycle after the rejected presentation, aligned with when valid_out would have appeared.

## Test plan
- Async reset: drive reset=0 between clock edges while valid_out=4'b0010 -> valid_out, data_out, rr_ptr and err_drop are 0 before the next rising edge; after release with no input, all stay 0.
- Select mode: mode=0, select=2, data_in=10'b1011001100, valid_in=1, pause=0 -> next cycle valid_out=4'b0100 and ch2 slice=10'b1011001100; other slices unchanged; rr_ptr unchanged.
- Round-robin wrap: mode=1, pause=0, four consecutive words 10'h201..10'h204 from rr_ptr=0 -> valid_out sequence 0001, 0010, 0100, 1000 carrying those words; rr_ptr goes 1, 2, 3, then wraps to 0.
- Round-robin skip: rr_ptr=1, pause=4'b0110, word 10'h3C3 -> delivered on ch3, rr_ptr=0. With pause=4'b1111 the next word gives ready_out=0, err_drop=1 next cycle, rr_ptr held at 0.
- Select backpressure: mode=0, select=1, pause=4'b0010, valid_in=1 -> ready_out=0, next cycle valid_out=0 and err_drop=1. Dropping pause[1] the following cycle delivers the next word to ch1.
- Mode switch: accept 2 words in mode 1 (rr_ptr to 2), then 3 words in mode 0 with select=0, then return to mode 1 -> next word goes to ch2.
